// File: rtl/full_adder_pkg.sv
// Shared arithmetic helpers and limits for the ripple-carry adder slice.
package full_adder_pkg;

  localparam int unsigned WIDTH_MAX = 64;

  function automatic logic fa_sum(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  function automatic logic fa_carry(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/full_adder_bit.sv
// Single-bit combinational full adder cell, chained by the top via carry.
module full_adder_bit
  import full_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = fa_sum(a, b, ci);
  assign co = fa_carry(a, b, ci);

endmodule

// File: rtl/full_adder.sv
// Parameterizable ripple-carry adder with outputs registered on an input strobe.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             valid_q;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder_bit u_bit (
      .a  (a[i]),
      .b  (b[i]),
      .ci (carry[i]),
      .s  (sum_d[i]),
      .co (carry[i+1])
    );
  end

  // Result registers only load on a strobe; out_valid is a one-cycle echo of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        sum_q  <= sum_d;
        cout_q <= carry[WIDTH];
      end
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_full_adder.sv
// Directed and table-driven checks for full_adder at WIDTH=1 and WIDTH=8.
module tb_full_adder;

  typedef struct {
    logic       a;
    logic       b;
    logic       cin;
    logic       exp_sum;
    logic       exp_cout;
  } vec1_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] exp_sum;
    logic       exp_cout;
  } vec8_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       iv1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       cin1 = 1'b0;
  logic [0:0] sum1;
  logic       cout1, ov1;

  logic       iv8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       cin8 = 1'b0;
  logic [7:0] sum8;
  logic       cout8, ov8;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .a(a1), .b(b1), .cin(cin1),
    .sum(sum1), .cout(cout1), .out_valid(ov1)
  );

  full_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .a(a8), .b(b8), .cin(cin8),
    .sum(sum8), .cout(cout8), .out_valid(ov8)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  vec1_t tbl1[8];
  vec8_t tbl8[5];

  initial begin
    logic [8:0] model;
    logic [7:0] ra, rb;
    logic       rc;

    tbl1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl1[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl1[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl1[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl1[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl1[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl1[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl1[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    tbl8[0] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
    tbl8[1] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tbl8[2] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    tbl8[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    tbl8[4] = '{8'h0F, 8'h01, 1'b1, 8'h11, 1'b0};

    // Reset state, with a clock edge passing while held
    @(posedge clk); #1;
    chk("rst_sum1", 64'(sum1), 64'd0);
    chk("rst_cout1", 64'(cout1), 64'd0);
    chk("rst_ov1", 64'(ov1), 64'd0);
    chk("rst_sum8", 64'(sum8), 64'd0);
    chk("rst_ov8", 64'(ov8), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=1 exhaustive truth table, back-to-back
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      iv1 = 1'b1; a1 = tbl1[i].a; b1 = tbl1[i].b; cin1 = tbl1[i].cin;
      @(posedge clk); #1;
      chk($sformatf("tt%0d_sum", i), 64'(sum1), 64'(tbl1[i].exp_sum));
      chk($sformatf("tt%0d_cout", i), 64'(cout1), 64'(tbl1[i].exp_cout));
      chk($sformatf("tt%0d_ov", i), 64'(ov1), 64'd1);
    end

    // Hold: capture 1+0+0, then drop strobe and change operands
    @(negedge clk);
    iv1 = 1'b1; a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0;
    @(posedge clk); #1;
    chk("hold_cap_sum", 64'(sum1), 64'd1);
    chk("hold_cap_cout", 64'(cout1), 64'd0);
    @(negedge clk);
    iv1 = 1'b0; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("hold%0d_sum", i), 64'(sum1), 64'd1);
      chk($sformatf("hold%0d_cout", i), 64'(cout1), 64'd0);
      chk($sformatf("hold%0d_ov", i), 64'(ov1), 64'd0);
    end

    // Async reset mid-stream, operands during reset discarded
    @(negedge clk);
    iv1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    @(posedge clk); #1;
    chk("pre_rst_sum", 64'(sum1), 64'd1);
    chk("pre_rst_cout", 64'(cout1), 64'd1);
    chk("pre_rst_ov", 64'(ov1), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_sum", 64'(sum1), 64'd0);
    chk("arst_cout", 64'(cout1), 64'd0);
    chk("arst_ov", 64'(ov1), 64'd0);
    @(posedge clk); #1;
    chk("arst_hold_sum", 64'(sum1), 64'd0);
    chk("arst_hold_cout", 64'(cout1), 64'd0);
    chk("arst_hold_ov", 64'(ov1), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; iv1 = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_sum", 64'(sum1), 64'd0);
    chk("post_rst_cout", 64'(cout1), 64'd0);
    chk("post_rst_ov", 64'(ov1), 64'd0);

    // WIDTH=8 directed vectors
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      iv8 = 1'b1; a8 = tbl8[i].a; b8 = tbl8[i].b; cin8 = tbl8[i].cin;
      @(posedge clk); #1;
      chk($sformatf("w8_%0d_sum", i), 64'(sum8), 64'(tbl8[i].exp_sum));
      chk($sformatf("w8_%0d_cout", i), 64'(cout8), 64'(tbl8[i].exp_cout));
      chk($sformatf("w8_%0d_ov", i), 64'(ov8), 64'd1);
    end

    // WIDTH=8 random back-to-back stream; inputs change right after each edge
    @(negedge clk);
    ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
    a8 = ra; b8 = rb; cin8 = rc; iv8 = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      model = 9'(ra) + 9'(rb) + 9'(rc);
      @(posedge clk); #1;
      chk("rnd_sum", 64'(sum8), 64'(model[7:0]));
      chk("rnd_cout", 64'(cout8), 64'(model[8]));
      chk("rnd_ov", 64'(ov8), 64'd1);
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      a8 = ra; b8 = rb; cin8 = rc;
    end
    @(negedge clk);
    iv8 = 1'b0;
    @(posedge clk); #1;
    chk("rnd_end_ov", 64'(ov8), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
